// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding, squashes wrong-path fetches.
// Optional IF_MISALIGN_CHECK_EN: adds sticky if_misaligned_out and halts fetch on an unaligned redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_take_branch_in,
  input  logic [31:0] ex_target_PC_in,
  input  logic        id_stall_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  output logic        if_valid_inst_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_IR_out
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        if_misaligned_out
`endif
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] out_pc_d, out_npc_d;
  logic        squash_q, squash_d;
  logic        valid_d;
  logic        halt_q;
  logic        out_busy;
  logic        req_fire;

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else if (ex_take_branch_in && (ex_target_PC_in[1:0] != 2'b00)) begin
      halt_q <= 1'b1;
    end
  end

  assign if_misaligned_out = halt_q;
`else
  assign halt_q = 1'b0;
`endif

  // A request is never launched while ID holds a stalled instruction, so a capture always has room.
  assign out_busy           = if_valid_inst_out & id_stall_in;
  assign imem_req_valid_out = (state_q == S_REQ) & ~out_busy & ~halt_q & ~rst;
  assign imem_req_addr_out  = pc_q;
  assign req_fire           = imem_req_valid_out & imem_req_ready_in;
  assign if_IR_out          = if_valid_inst_out ? ir_q : NOP_INST;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    squash_d  = squash_q;
    valid_d   = if_valid_inst_out & id_stall_in;
    ir_d      = ir_q;
    out_pc_d  = if_PC_out;
    out_npc_d = if_NPC_out;
    if (ex_take_branch_in) begin
      // Redirect wins; a request accepted on this edge carries the old PC and must be squashed.
      pc_d    = ex_target_PC_in & ~32'h3;
      valid_d = 1'b0;
      ir_d    = NOP_INST;
      if (state_q == S_WAIT) begin
        if (imem_rsp_valid_in) begin
          state_d  = S_REQ;
          squash_d = 1'b0;
        end else begin
          squash_d = 1'b1;
        end
      end else if (req_fire) begin
        state_d  = S_WAIT;
        squash_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d  = S_WAIT;
            squash_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid_in) begin
            state_d  = S_REQ;
            squash_d = 1'b0;
            if (!squash_q && !halt_q) begin
              valid_d   = 1'b1;
              ir_d      = imem_rsp_data_in;
              out_pc_d  = pc_q;
              out_npc_d = pc_q + 32'd4;
              pc_d      = pc_q + 32'd4;
            end
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_REQ;
      pc_q              <= RESET_PC;
      squash_q          <= 1'b0;
      if_valid_inst_out <= 1'b0;
      ir_q              <= NOP_INST;
      if_PC_out         <= 32'h0;
      if_NPC_out        <= 32'h0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      squash_q          <= squash_d;
      if_valid_inst_out <= valid_d;
      ir_q              <= ir_d;
      if_PC_out         <= out_pc_d;
      if_NPC_out        <= out_npc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a memory responder plus a transaction-level fetch model predicts every output.
// Exercises IF_MISALIGN_CHECK_EN behaviour when that macro is defined.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_take_branch_in;
  logic [31:0] ex_target_PC_in;
  logic        id_stall_in;
  logic        imem_req_valid_out;
  logic        imem_req_ready_in;
  logic [31:0] imem_req_addr_out;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic        if_valid_inst_out;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_IR_out;
`ifdef IF_MISALIGN_CHECK_EN
  logic        if_misaligned_out;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk),
    .rst(rst),
    .ex_take_branch_in(ex_take_branch_in),
    .ex_target_PC_in(ex_target_PC_in),
    .id_stall_in(id_stall_in),
    .imem_req_valid_out(imem_req_valid_out),
    .imem_req_ready_in(imem_req_ready_in),
    .imem_req_addr_out(imem_req_addr_out),
    .imem_rsp_valid_in(imem_rsp_valid_in),
    .imem_rsp_data_in(imem_rsp_data_in),
    .if_valid_inst_out(if_valid_inst_out),
    .if_PC_out(if_PC_out),
    .if_NPC_out(if_NPC_out),
    .if_IR_out(if_IR_out)
`ifdef IF_MISALIGN_CHECK_EN
    , .if_misaligned_out(if_misaligned_out)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: is a fetch in flight, is it doomed, what does ID currently see.
  bit          m_pending, m_squash, m_valid, m_halt;
  logic [31:0] m_pc, m_inflight, m_out_pc, m_out_ir;

  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  int          ready_pct, stall_pct, branch_pct, stray_pct, lat_min, lat_max;
  bit          force_stall, force_branch;
  logic [31:0] force_target;

  logic [31:0] obs_pc[$];
  logic [31:0] obs_ir[$];
  logic [31:0] req_log[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] randTarget();
    logic [31:0] t;
    t = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFF);
`ifdef IF_MISALIGN_CHECK_EN
    t = t & ~32'h3;
`endif
    return t;
  endfunction

  task automatic resetDut();
    rst               = 1'b1;
    ex_take_branch_in = 1'b0;
    ex_target_PC_in   = 32'h0;
    id_stall_in       = 1'b0;
    imem_req_ready_in = 1'b0;
    imem_rsp_valid_in = 1'b0;
    imem_rsp_data_in  = 32'h0;
    m_pending = 0; m_squash = 0; m_valid = 0; m_halt = 0;
    m_pc = 32'h0; m_inflight = 32'h0; m_out_pc = 32'h0; m_out_ir = NOP;
    mem_busy = 0; mem_cnt = 0;
    #1;
    checkOutput("rst_valid", if_valid_inst_out, 1'b0);
    checkOutput("rst_pc", if_PC_out, 32'h0);
    checkOutput("rst_npc", if_NPC_out, 32'h0);
    checkOutput("rst_ir", if_IR_out, NOP);
    checkOutput("rst_req", imem_req_valid_out, 1'b0);
`ifdef IF_MISALIGN_CHECK_EN
    checkOutput("rst_misaligned", if_misaligned_out, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock per iteration; called and returns at a falling edge.
  task automatic applyStimulus(input int cycles);
    bit          exp_req, consumed, accepted, got_rsp;
    logic [31:0] tgt, req_addr;
    repeat (cycles) begin
      checkOutput("valid", if_valid_inst_out, m_valid);
      if (m_valid) begin
        checkOutput("pc", if_PC_out, m_out_pc);
        checkOutput("npc", if_NPC_out, m_out_pc + 32'd4);
        checkOutput("ir", if_IR_out, m_out_ir);
      end else begin
        checkOutput("ir_nop", if_IR_out, NOP);
      end
`ifdef IF_MISALIGN_CHECK_EN
      checkOutput("misaligned", if_misaligned_out, m_halt);
`endif
      if (if_valid_inst_out && (obs_pc.size() == 0 || obs_pc[$] != if_PC_out)) begin
        obs_pc.push_back(if_PC_out);
        obs_ir.push_back(if_IR_out);
      end

      id_stall_in       = force_stall || ($urandom_range(99) < stall_pct);
      imem_req_ready_in = ($urandom_range(99) < ready_pct);
      ex_take_branch_in = force_branch || ($urandom_range(99) < branch_pct);
      tgt               = force_branch ? force_target : randTarget();
      ex_target_PC_in   = ex_take_branch_in ? tgt : $urandom;
      force_branch      = 0;
      imem_rsp_valid_in = 1'b0;
      imem_rsp_data_in  = $urandom;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rsp_valid_in = 1'b1;
          imem_rsp_data_in  = mem_addr ^ KEY;
          mem_busy          = 0;
        end
      end else if (!m_pending && ($urandom_range(99) < stray_pct)) begin
        imem_rsp_valid_in = 1'b1;
      end

      #1;
      exp_req = !m_pending && !(m_valid && id_stall_in) && !m_halt;
      checkOutput("req_valid", imem_req_valid_out, exp_req);
      if (exp_req) checkOutput("req_addr", imem_req_addr_out, m_pc);
      req_addr = imem_req_addr_out;

      @(posedge clk);
      consumed = m_valid && !id_stall_in;
      accepted = exp_req && imem_req_ready_in;
      got_rsp  = m_pending && imem_rsp_valid_in;
      if (consumed) m_valid = 0;
      if (ex_take_branch_in) begin
        m_valid = 0;
`ifdef IF_MISALIGN_CHECK_EN
        if (ex_target_PC_in[1:0] != 2'b00) m_halt = 1;
`endif
        if (got_rsp) begin
          m_pending = 0;
          m_squash  = 0;
        end else if (m_pending) begin
          m_squash = 1;
        end else if (accepted) begin
          m_pending = 1;
          m_squash  = 1;
        end
        m_pc = {ex_target_PC_in[31:2], 2'b00};
      end else if (accepted) begin
        m_pending  = 1;
        m_squash   = 0;
        m_inflight = m_pc;
      end else if (got_rsp) begin
        if (!m_squash && !m_halt) begin
          m_valid  = 1;
          m_out_pc = m_inflight;
          m_out_ir = m_inflight ^ KEY;
          m_pc     = m_inflight + 32'd4;
        end
        m_pending = 0;
        m_squash  = 0;
      end
      if (accepted) begin
        req_log.push_back(req_addr);
        mem_busy = 1;
        mem_cnt  = $urandom_range(lat_max, lat_min);
        mem_addr = req_addr;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitValid(input logic [31:0] pc, input string tag);
    for (int i = 0; i < 50; i++) begin
      if (if_valid_inst_out && if_PC_out == pc) break;
      applyStimulus(1);
    end
    checkOutput(tag, (if_valid_inst_out && if_PC_out == pc), 1'b1);
  endtask

  task automatic waitPending();
    for (int i = 0; i < 50; i++) begin
      if (m_pending) break;
      applyStimulus(1);
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    force_branch = 1;
    force_target = target;
    applyStimulus(1);
    req_log.delete();
    obs_pc.delete();
    obs_ir.delete();
  endtask

  initial begin
    bit found8;
    ready_pct = 100; stall_pct = 0; branch_pct = 0; stray_pct = 0;
    lat_min = 1; lat_max = 1;
    force_stall = 0; force_branch = 0; force_target = 32'h0;

    resetDut();
    waitValid(32'h4, "reach_pc4");
    force_stall = 1;
    applyStimulus(5);
    checkOutput("stall_pc", if_PC_out, 32'h4);
    checkOutput("stall_npc", if_NPC_out, 32'h8);
    checkOutput("stall_ir", if_IR_out, 32'hA5A5_0004);
    checkOutput("stall_req", imem_req_valid_out, 1'b0);
    force_stall = 0;
    req_log.delete();
    applyStimulus(6);
    checkOutput("seq_ir0", qget(obs_ir, 0), 32'hA5A5_0000);
    checkOutput("seq_ir1", qget(obs_ir, 1), 32'hA5A5_0004);
    checkOutput("seq_ir2", qget(obs_ir, 2), 32'hA5A5_0008);
    checkOutput("seq_pc2", qget(obs_pc, 2), 32'h8);
    checkOutput("resume_req", qget(req_log, 0), 32'h8);

    resetDut();
    lat_min = 3; lat_max = 3;
    waitPending();
    redirect(32'h100);
    applyStimulus(12);
    checkOutput("rdw_req", qget(req_log, 0), 32'h100);
    checkOutput("rdw_pc", qget(obs_pc, 0), 32'h100);
    checkOutput("rdw_ir", qget(obs_ir, 0), 32'hA5A5_0100);

    resetDut();
    lat_min = 1; lat_max = 1;
    waitValid(32'h4, "reach_pc4_b");
    req_log.delete();
    force_branch = 1;
    force_target = 32'h200;
    applyStimulus(1);
    obs_pc.delete();
    obs_ir.delete();
    applyStimulus(8);
    checkOutput("sed_req0", qget(req_log, 0), 32'h8);
    checkOutput("sed_req1", qget(req_log, 1), 32'h200);
    checkOutput("sed_pc0", qget(obs_pc, 0), 32'h200);
    found8 = 0;
    foreach (obs_pc[i]) if (obs_pc[i] == 32'h8) found8 = 1;
    checkOutput("sed_no_pc8", found8, 1'b0);

    resetDut();
    applyStimulus(2);
    redirect(32'hFFFF_FFFC);
    applyStimulus(8);
    checkOutput("wrap_pc0", qget(obs_pc, 0), 32'hFFFF_FFFC);
    checkOutput("wrap_ir0", qget(obs_ir, 0), 32'h5A5A_FFFC);
    checkOutput("wrap_pc1", qget(obs_pc, 1), 32'h0);

    resetDut();
    applyStimulus(3);
    redirect(32'h203);
    applyStimulus(8);
`ifdef IF_MISALIGN_CHECK_EN
    checkOutput("mis_flag", if_misaligned_out, 1'b1);
    checkOutput("mis_no_req", req_log.size(), 0);
`else
    checkOutput("mis_req", qget(req_log, 0), 32'h200);
    checkOutput("mis_pc", qget(obs_pc, 0), 32'h200);
`endif

    resetDut();
    lat_min = 3; lat_max = 3;
    waitPending();
    resetDut();
    stray_pct = 100; ready_pct = 0;
    applyStimulus(4);
    checkOutput("rmw_valid", if_valid_inst_out, 1'b0);
    checkOutput("rmw_ir", if_IR_out, NOP);
    checkOutput("rmw_pc", if_PC_out, 32'h0);
    stray_pct = 0; ready_pct = 100;
    req_log.delete();
    applyStimulus(4);
    checkOutput("rmw_req0", qget(req_log, 0), 32'h0);

    resetDut();
    ready_pct = 70; stall_pct = 30; branch_pct = 5; stray_pct = 20;
    lat_min = 1; lat_max = 4;
    applyStimulus(1500);
    resetDut();
    applyStimulus(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
